// File: rtl/axi4_burst_sram_slave.sv
// rtl/axi4_burst_sram_slave.sv - AXI4 burst SRAM slave with FIXED/INCR/WRAP addressing and configurable read latency
// Optional macro AXI_SRAM_WRAP_EN enables WRAP bursts; without it WRAP is INCR plus SLVERR.
module axi4_burst_sram_slave #(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                ID_W        = 4,
   parameter int                DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h80000000,
   parameter int                READ_LAT    = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                awvalid,
   output logic                awready,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [ID_W-1:0]     awid,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                wvalid,
   output logic                wready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   output logic                bvalid,
   input  logic                bready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   input  logic                arvalid,
   output logic                arready,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [ID_W-1:0]     arid,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   output logic                rvalid,
   input  logic                rready,
   output logic [DATA_W-1:0]   rdata,
   output logic [ID_W-1:0]     rid,
   output logic [1:0]          rresp,
   output logic                rlast
);
   localparam int STRB_W = DATA_W / 8;
   localparam int LOG_B  = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH_WORDS * STRB_W);
`ifdef AXI_SRAM_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] off;
      off = a - BASE_ADDR;
      return (a >= BASE_ADDR) && (off < SPAN);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> LOG_B);
   endfunction

   function automatic logic wrap_ok(input logic [1:0] burst, input logic [7:0] len);
      return WRAP_EN && (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
   endfunction

   function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len, input logic [2:0] size);
      return (size > 3'(LOG_B)) || (burst[1] && !wrap_ok(burst, len));
   endfunction

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [2:0] size,
                                                   input logic [7:0] len, input logic fixed, input logic wrap);
      logic [ADDR_W-1:0] inc, bound;
      inc   = a + (ADDR_W'(1) << size);
      bound = (ADDR_W'(len) + ADDR_W'(1)) << size;
      if (fixed)     return a;
      else if (wrap) return (a & ~(bound - 1'b1)) | (inc & (bound - 1'b1));
      else           return inc;
   endfunction

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   w_state_t          w_state;
   logic [ADDR_W-1:0] w_addr;
   logic [ID_W-1:0]   w_id;
   logic [7:0]        w_cnt, w_len;
   logic [2:0]        w_size;
   logic              w_fixed, w_wrap, w_err, w_size_err, w_err_next, mem_we;

   r_state_t          r_state;
   logic [ADDR_W-1:0] r_addr, r_next, load_addr;
   logic [7:0]        r_cnt, r_len;
   logic [2:0]        r_size;
   logic              r_fixed, r_wrap, r_err, load_err;
   logic [15:0]       r_wait;
   logic [DATA_W-1:0] load_data;

   always_comb begin
      w_err_next = w_err || !in_range(w_addr) || (wlast != (w_cnt == 8'd0));
      mem_we     = !reset && (w_state == W_DATA) && wvalid && !w_size_err && in_range(w_addr);
   end

   // Source of the next read beat: the new descriptor, the waiting start address, or the burst successor.
   always_comb begin
      r_next    = next_addr(r_addr, r_size, r_len, r_fixed, r_wrap);
      load_addr = r_next;
      load_err  = r_err;
      if (r_state == R_IDLE) begin
         load_addr = araddr;
         load_err  = burst_err(arburst, arlen, arsize);
      end else if (r_state == R_WAIT) begin
         load_addr = r_addr;
      end
      load_err  = load_err || !in_range(load_addr);
      load_data = in_range(load_addr) ? mem[word_idx(load_addr)] : '0;
   end

   always_ff @(posedge clock) begin
      if (mem_we)
         for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state <= W_IDLE;
         awready <= 1'b1;
         wready  <= 1'b0;
         bvalid  <= 1'b0;
         bid     <= '0;
         bresp   <= 2'b00;
      end else begin
         case (w_state)
            W_IDLE: if (awvalid) begin
               awready    <= 1'b0;
               wready     <= 1'b1;
               w_addr     <= awaddr;
               w_id       <= awid;
               w_cnt      <= awlen;
               w_len      <= awlen;
               w_size     <= awsize;
               w_fixed    <= (awburst == 2'b00);
               w_wrap     <= wrap_ok(awburst, awlen);
               w_err      <= burst_err(awburst, awlen, awsize);
               w_size_err <= (awsize > 3'(LOG_B));
               w_state    <= W_DATA;
            end
            W_DATA: if (wvalid) begin
               w_addr <= next_addr(w_addr, w_size, w_len, w_fixed, w_wrap);
               w_cnt  <= w_cnt - 8'd1;
               w_err  <= w_err_next;
               if (w_cnt == 8'd0) begin
                  wready  <= 1'b0;
                  bvalid  <= 1'b1;
                  bid     <= w_id;
                  bresp   <= w_err_next ? 2'b10 : 2'b00;
                  w_state <= W_RESP;
               end
            end
            W_RESP: if (bready) begin
               bvalid  <= 1'b0;
               awready <= 1'b1;
               w_state <= W_IDLE;
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= R_IDLE;
         arready <= 1'b1;
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         rid     <= '0;
         rresp   <= 2'b00;
         rdata   <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid) begin
               arready <= 1'b0;
               rid     <= arid;
               r_addr  <= araddr;
               r_cnt   <= arlen;
               r_len   <= arlen;
               r_size  <= arsize;
               r_fixed <= (arburst == 2'b00);
               r_wrap  <= wrap_ok(arburst, arlen);
               r_err   <= burst_err(arburst, arlen, arsize);
               if (READ_LAT <= 1) begin
                  rvalid  <= 1'b1;
                  rdata   <= load_data;
                  rresp   <= load_err ? 2'b10 : 2'b00;
                  rlast   <= (arlen == 8'd0);
                  r_state <= R_DATA;
               end else begin
                  r_wait  <= 16'(READ_LAT - 2);
                  r_state <= R_WAIT;
               end
            end
            R_WAIT: if (r_wait == 16'd0) begin
               rvalid  <= 1'b1;
               rdata   <= load_data;
               rresp   <= load_err ? 2'b10 : 2'b00;
               rlast   <= (r_cnt == 8'd0);
               r_state <= R_DATA;
            end else begin
               r_wait <= r_wait - 16'd1;
            end
            R_DATA: if (rready) begin
               if (r_cnt != 8'd0) begin
                  r_addr <= r_next;
                  r_cnt  <= r_cnt - 8'd1;
                  rdata  <= load_data;
                  rresp  <= load_err ? 2'b10 : 2'b00;
                  rlast  <= (r_cnt == 8'd1);
               end else begin
                  rvalid  <= 1'b0;
                  rlast   <= 1'b0;
                  arready <= 1'b1;
                  r_state <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_burst_sram_slave.sv
// tb/tb_axi4_burst_sram_slave.sv - directed self-checking bench for axi4_burst_sram_slave
// Built with READ_LAT=3 and a 256-word array so the top-of-array boundary is 0x80000400.
module tb_axi4_burst_sram_slave;
   logic        clock = 1'b0, reset = 1'b1;
   logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
   logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
   logic [3:0]  awid = 0, wstrb = 0, bid, arid = 0, rid;
   logic [7:0]  awlen = 0, arlen = 0;
   logic [2:0]  awsize = 0, arsize = 0;
   logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;
   logic        arvalid = 0, arready, rvalid, rready = 0, rlast;

   int tests = 0, failed = 0;
   logic [31:0] wbuf [16];
   logic [31:0] rbuf [16];
   logic [1:0]  rrbuf [16];
   logic        rlbuf [16];
   logic [1:0]  b_resp;
   logic [3:0]  b_id, r_id;
   logic        b_prompt;
   int          r_lat, r_cycles, unstable;

   axi4_burst_sram_slave #(.DEPTH_WORDS(256), .READ_LAT(3)) dut (
      .clock(clock), .reset(reset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
      .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic timeout(input string what);
      tests++; failed++;
      $display("FAIL timeout %s: handshake never came", what);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                            input int last_at);
      int n;
      awvalid = 1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = burst;
      n = 0; while (!awready && n < 50) begin tick(); n++; end
      if (n == 50) timeout("aw");
      tick(); awvalid = 0;
      for (int i = 0; i <= int'(len); i++) begin
         wvalid = 1; wdata = wbuf[i]; wstrb = strb; wlast = (i == last_at);
         n = 0; while (!wready && n < 50) begin tick(); n++; end
         if (n == 50) timeout("w");
         tick();
      end
      wvalid = 0; wlast = 0;
      b_prompt = bvalid; bready = 1;
      n = 0; while (!bvalid && n < 50) begin tick(); n++; end
      if (n == 50) timeout("b");
      b_resp = bresp; b_id = bid;
      tick(); bready = 0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
      int n, beat;
      logic held, hl;
      logic [31:0] hd;
      arvalid = 1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
      n = 0; while (!arready && n < 50) begin tick(); n++; end
      if (n == 50) timeout("ar");
      tick(); arvalid = 0;
      r_lat = 1; while (!rvalid && r_lat < 50) begin tick(); r_lat++; end
      beat = 0; r_cycles = 0; held = 0; unstable = 0; hd = 0; hl = 0;
      while (beat <= int'(len) && r_cycles < 200) begin
         rready = toggle ? (r_cycles % 2 == 0) : 1'b1;
         if (held && (!rvalid || rdata !== hd || rlast !== hl)) unstable++;
         held = rvalid && !rready; hd = rdata; hl = rlast;
         if (rvalid && rready) begin
            rbuf[beat] = rdata; rrbuf[beat] = rresp; rlbuf[beat] = rlast; r_id = rid; beat++;
         end
         tick(); r_cycles++;
      end
      rready = 0;
      if (beat <= int'(len)) timeout("r");
   endtask

   task automatic test_reset();
      repeat (3) tick();
      reset = 0;
      tests++; if ({awready, arready} !== 2'b11) begin failed++; $display("FAIL reset_ready: got %b expected 11", {awready, arready}); end
      tests++; if ({wready, bvalid, rvalid, rlast} !== 4'b0) begin failed++; $display("FAIL reset_valid: got %b expected 0000", {wready, bvalid, rvalid, rlast}); end
      tests++; if ({bresp, rresp, bid, rid, rdata} !== 44'h0) begin failed++; $display("FAIL reset_outputs: got %h expected 0", {bresp, rresp, bid, rid, rdata}); end
   endtask

   task automatic test_single();
      wbuf[0] = 32'hDEADBEEF;
      axi_write(32'h80000010, 4'd3, 8'd0, 3'd2, 2'b01, 4'hF, 0);
      tests++; if (b_prompt !== 1'b1) begin failed++; $display("FAIL single_b_latency: bvalid %b expected 1", b_prompt); end
      tests++; if ({b_id, b_resp} !== {4'd3, 2'b00}) begin failed++; $display("FAIL single_bresp: got %h expected %h", {b_id, b_resp}, {4'd3, 2'b00}); end
      axi_read(32'h80000010, 4'd5, 8'd0, 3'd2, 2'b01, 0);
      tests++; if (rbuf[0] !== 32'hDEADBEEF) begin failed++; $display("FAIL single_rdata: got %h expected deadbeef", rbuf[0]); end
      tests++; if ({r_id, rrbuf[0], rlbuf[0]} !== {4'd5, 2'b00, 1'b1}) begin failed++; $display("FAIL single_rid: got %h expected %h", {r_id, rrbuf[0], rlbuf[0]}, {4'd5, 2'b00, 1'b1}); end
   endtask

   task automatic test_incr_burst();
      for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
      axi_write(32'h80000000, 4'd1, 8'd3, 3'd2, 2'b01, 4'hF, 3);
      tests++; if (b_resp !== 2'b00) begin failed++; $display("FAIL incr_bresp: got %b expected 00", b_resp); end
      axi_read(32'h80000000, 4'd2, 8'd3, 3'd2, 2'b01, 0);
      tests++; if (r_lat !== 3) begin failed++; $display("FAIL incr_latency: got %0d expected 3", r_lat); end
      tests++; if (r_cycles !== 4) begin failed++; $display("FAIL incr_back_to_back: got %0d cycles expected 4", r_cycles); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (rbuf[i] !== 32'(i + 1) || rlbuf[i] !== (i == 3)) begin
            failed++; $display("FAIL incr_beat%0d: got %h/%b expected %h/%b", i, rbuf[i], rlbuf[i], i + 1, i == 3); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] e_data [4];
      logic [1:0]  e_resp;
      wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC; wbuf[3] = 32'hD; wbuf[4] = 32'hE; wbuf[5] = 32'hF;
      axi_write(32'h80000000, 4'd1, 8'd5, 3'd2, 2'b01, 4'hF, 5);
`ifdef AXI_SRAM_WRAP_EN
      e_data = '{32'hC, 32'hD, 32'hA, 32'hB}; e_resp = 2'b00;
`else
      e_data = '{32'hC, 32'hD, 32'hE, 32'hF}; e_resp = 2'b10;
`endif
      axi_read(32'h80000008, 4'd4, 8'd3, 3'd2, 2'b10, 0);
      for (int i = 0; i < 4; i++) begin
         tests++; if ({rbuf[i], rrbuf[i]} !== {e_data[i], e_resp}) begin
            failed++; $display("FAIL wrap_beat%0d: got %h/%b expected %h/%b", i, rbuf[i], rrbuf[i], e_data[i], e_resp); end
      end
      axi_read(32'h80000000, 4'd4, 8'd2, 3'd2, 2'b10, 0);
      tests++; if ({rbuf[2], rrbuf[2], rlbuf[2]} !== {32'hC, 2'b10, 1'b1}) begin
         failed++; $display("FAIL wrap_badlen: got %h/%b/%b expected c/10/1", rbuf[2], rrbuf[2], rlbuf[2]); end
      axi_read(32'h80000004, 4'd4, 8'd1, 3'd2, 2'b00, 0);
      tests++; if ({rbuf[0], rbuf[1], rrbuf[1]} !== {32'hB, 32'hB, 2'b00}) begin
         failed++; $display("FAIL fixed_read: got %h %h/%b expected b b/00", rbuf[0], rbuf[1], rrbuf[1]); end
      axi_read(32'h80000000, 4'd4, 8'd1, 3'd2, 2'b11, 0);
      tests++; if ({rbuf[1], rrbuf[0]} !== {32'hB, 2'b10}) begin
         failed++; $display("FAIL burst11_read: got %h/%b expected b/10", rbuf[1], rrbuf[0]); end
   endtask

   task automatic test_strobe_range();
      wbuf[0] = 32'h11223344;
      axi_write(32'h80000020, 4'd1, 8'd0, 3'd2, 2'b01, 4'hF, 0);
      wbuf[0] = 32'h0000AB00;
      axi_write(32'h80000020, 4'd1, 8'd0, 3'd2, 2'b01, 4'h2, 0);
      axi_read(32'h80000020, 4'd1, 8'd0, 3'd2, 2'b01, 0);
      tests++; if (rbuf[0] !== 32'h1122AB44) begin failed++; $display("FAIL strobe_merge: got %h expected 1122ab44", rbuf[0]); end
      axi_read(32'h90000000, 4'd1, 8'd0, 3'd2, 2'b01, 0);
      tests++; if ({rbuf[0], rrbuf[0]} !== {32'h0, 2'b10}) begin failed++; $display("FAIL oor_read: got %h/%b expected 0/10", rbuf[0], rrbuf[0]); end
      wbuf[0] = 32'h55;
      axi_write(32'h800003FC, 4'd1, 8'd0, 3'd2, 2'b01, 4'hF, 0);
      axi_read(32'h800003FC, 4'd1, 8'd1, 3'd2, 2'b01, 0);
      tests++; if ({rbuf[0], rrbuf[0], rbuf[1], rrbuf[1]} !== {32'h55, 2'b00, 32'h0, 2'b10}) begin
         failed++; $display("FAIL top_boundary: got %h/%b %h/%b expected 55/00 0/10", rbuf[0], rrbuf[0], rbuf[1], rrbuf[1]); end
      wbuf[0] = 32'h99;
      axi_write(32'h80000400, 4'd6, 8'd0, 3'd2, 2'b01, 4'hF, 0);
      tests++; if ({b_id, b_resp} !== {4'd6, 2'b10}) begin failed++; $display("FAIL oor_bresp: got %h expected %h", {b_id, b_resp}, {4'd6, 2'b10}); end
      wbuf[0] = 32'hBAD;
      axi_write(32'h80000000, 4'd1, 8'd0, 3'd3, 2'b01, 4'hF, 0);
      tests++; if (b_resp !== 2'b10) begin failed++; $display("FAIL size_bresp: got %b expected 10", b_resp); end
      axi_read(32'h80000000, 4'd1, 8'd0, 3'd2, 2'b01, 0);
      tests++; if (rbuf[0] !== 32'hA) begin failed++; $display("FAIL array_unchanged: got %h expected a", rbuf[0]); end
   endtask

   task automatic test_backpressure();
      axi_read(32'h80000000, 4'd7, 8'd3, 3'd2, 2'b01, 1);
      tests++; if (unstable !== 0) begin failed++; $display("FAIL stall_stable: got %0d changes expected 0", unstable); end
      tests++; if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'hA, 32'hB, 32'hC, 32'hD}) begin
         failed++; $display("FAIL stall_beats: got %h %h %h %h expected a b c d", rbuf[0], rbuf[1], rbuf[2], rbuf[3]); end
      tests++; if ({rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]} !== 4'b0001) begin
         failed++; $display("FAIL stall_rlast: got %b expected 0001", {rlbuf[0], rlbuf[1], rlbuf[2], rlbuf[3]}); end
      wbuf[0] = 32'h77; wbuf[1] = 32'h88;
      axi_write(32'h80000040, 4'd2, 8'd1, 3'd2, 2'b01, 4'hF, 0);
      tests++; if (b_resp !== 2'b10) begin failed++; $display("FAIL early_wlast: got %b expected 10", b_resp); end
      axi_read(32'h80000040, 4'd2, 8'd1, 3'd2, 2'b01, 0);
      tests++; if ({rbuf[0], rbuf[1]} !== {32'h77, 32'h88}) begin failed++; $display("FAIL early_wlast_data: got %h %h expected 77 88", rbuf[0], rbuf[1]); end
   endtask

   task automatic test_reset_mid_burst();
      int n;
      arvalid = 1; araddr = 32'h80000000; arid = 4'd1; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
      tick(); arvalid = 0;
      n = 0; while (!rvalid && n < 50) begin tick(); n++; end
      if (n == 50) timeout("mid_r");
      rready = 1; tick(); tick();
      reset = 1; rready = 0; tick();
      tests++; if ({rvalid, arready, awready} !== 3'b011) begin failed++; $display("FAIL mid_reset: got %b expected 011", {rvalid, arready, awready}); end
      reset = 0; tick();
      axi_read(32'h80000000, 4'd1, 8'd3, 3'd2, 2'b01, 0);
      tests++; if ({rbuf[0], rbuf[1], rbuf[2], rbuf[3]} !== {32'hA, 32'hB, 32'hC, 32'hD}) begin
         failed++; $display("FAIL mid_reread: got %h %h %h %h expected a b c d", rbuf[0], rbuf[1], rbuf[2], rbuf[3]); end
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_incr_burst();
      test_wrap();
      test_strobe_range();
      test_backpressure();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/axi4_burst_sram_slave.md
Name: axi4_burst_sram_slave

Overview:
Parametrised AXI4 slave memory for the npc simulation top. It is the next generation of the single-beat-write DPI memory model.
- Internal byte-enabled word array, configurable data/ID width and depth.
- Multi-beat write bursts; FIXED/INCR/WRAP address generation; configurable read latency.
- ID echo and SLVERR reporting.
- Sits between the core's io_master AXI4 port and the address decoder, in place of the memory path.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width in bits (32 or 64)
ID_W, 4, AXI ID width
DEPTH_WORDS, 1024, number of DATA_W words in the array (power of 2)
BASE_ADDR, 32'h80000000, byte address of word 0
READ_LAT, 1, cycles from AR handshake to first rvalid (>=1)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
awvalid/awready  in/out  1  write address handshake
awaddr  in  ADDR_W  burst start byte address
awid  in  ID_W  write ID
awlen  in  8  beats-1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
wvalid/wready  in/out  1  write data handshake
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
wlast  in  1  last write beat
bvalid/bready  out/in  1  write response handshake
bid  out  ID_W  echoed awid
bresp  out  2  00 OKAY, 10 SLVERR
arvalid/arready  in/out  1  read address handshake
araddr, arid, arlen, arsize, arburst  in  ADDR_W, ID_W, 8, 3, 2  read burst descriptor
rvalid/rready  out/in  1  read data handshake
rdata  out  DATA_W  read data
rid  out  ID_W  echoed arid
rresp  out  2  per-beat response
rlast  out  1  last read beat

Behaviour:
- Clocking: reset is synchronous, active-high; clock is clock.
- Reset values: awready=1, arready=1; wready, bvalid, rvalid, rlast=0; bresp, rresp, bid, rid, rdata=0. Array contents are not cleared.
- Reset mid-burst: both FSMs return to IDLE next cycle; the burst is abandoned; beats already written stay written.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready=1. On AW handshake, latch addr/id/len/size/burst, set beat counter=awlen, clear err flag, go W_DATA with wready=1 next cycle.
  - W_DATA: each W handshake writes the bytes enabled by wstrb at the current word, then advances the address and decrements the counter.
  - Write burst ends on the beat where the counter==0, regardless of wlast. wlast mismatch (wlast on counter!=0, or !wlast on counter==0) sets the err flag.
  - W_RESP: bvalid=1, bid=latched id, bresp=SLVERR if err flag else OKAY. Hold until bready, then W_IDLE with awready=1 the next cycle.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE.
  - R_IDLE: arready=1. On AR handshake, latch the descriptor; R_WAIT counts READ_LAT-1 cycles (skipped when READ_LAT=1).
  - R_DATA: rvalid=1 with registered rdata, rid=latched id, rlast=(counter==0).
  - On R handshake: if counter!=0, load the next beat in the same edge so rvalid stays 1 (back-to-back beats); else go R_IDLE.
  - rdata, rresp and rlast hold stable while rvalid & !rready.
- Address generation (byte addresses), size S = 1<<axsize:
  - FIXED: address unchanged.
  - INCR: addr + S.
  - WRAP: boundary B = S*(len+1); next = (addr & ~(B-1)) | ((addr+S) & (B-1)).
  - Word index = (addr-BASE_ADDR) >> log2(DATA_W/8), truncated to log2(DEPTH_WORDS) bits.
- Error rules (SLVERR, beat still completes):
  - Address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*DATA_W/8): write beat suppressed; read rdata=0.
  - axsize > log2(DATA_W/8): whole burst SLVERR, no array writes.
  - axburst=11: treated as INCR plus SLVERR.
  - WRAP with len not in {1,3,7,15}: treated as INCR plus SLVERR.
- Simultaneous events:
  - Read and write channels run fully in parallel.
  - A read beat loaded in the same cycle as a write to the same word returns the old data (read-before-write).
  - AW accepted while the R burst is active is allowed, and the reverse.

Optional Feature:
AXI_SRAM_WRAP_EN
- Defined: WRAP bursts are supported as described.
- Undefined: WRAP (10) is handled like burst=11, i.e. INCR addressing with SLVERR on every beat/response.

Test Plan:
- Reset, then single INCR write: awaddr=0x80000010, awlen=0, wdata=0xDEADBEEF, wstrb=0xF -> bvalid 1 cycle after W handshake, bresp=00, bid=awid=3. Read of same addr -> rdata=0xDEADBEEF, rlast=1, rid=arid.
- INCR burst: write awlen=3 at 0x80000000 (data 1,2,3,4), then read arlen=3 with READ_LAT=3 -> first rvalid 3 cycles after AR handshake, beats 1,2,3,4 back-to-back with rready=1, rlast only on beat 4.
- WRAP (macro defined): write 0xA,0xB,0xC,0xD at word 0-3, then read 0x80000008 with arlen=3, arburst=10, arsize=2 -> beats 0xC,0xD,0xA,0xB.
- Partial strobe and out-of-range: wstrb=0x2, wdata=0x0000AB00 onto 0x11223344 -> reads 0x1122AB44. Read at 0x90000000 -> rresp=10, rdata=0. Write there -> bresp=10, array unchanged.
- Backpressure and error flag: rready toggled 1/0 during a 4-beat read -> rdata/rlast stable while stalled, no beat lost. Write awlen=1 with wlast on beat 0 -> 2 beats accepted, bresp=10.
- Reset mid-burst: assert reset after beat 1 of a 4-beat read -> rvalid=0, arready=1 next cycle, previously written data intact on re-read.
